// File: rtl/uart_rx_parity_checker_gen.sv
// uart_rx_parity_checker_gen
// Parity checker for the UART receive datapath. Data bits are collected by
// frame index, a running parity is kept, and the received parity bit is checked
// in even, odd, mark or space mode. One result is reported per frame, with a
// one-cycle done strobe.
// Optional feature: define PAR_CHK_ERR_CNT_EN to add a saturating parity-error
// counter on the err_cnt port.
module uart_rx_parity_checker_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_W      = 4,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  par_en,
   input  logic [1:0]            par_mode,
   input  logic                  sample_valid,
   input  logic [CNT_W-1:0]      bit_cnt,
   input  logic                  sampled_bit,
   input  logic                  frame_abort,
   output logic [DATA_WIDTH-1:0] par_data,
   output logic                  par_done,
   output logic                  par_err
`ifdef PAR_CHK_ERR_CNT_EN
   ,
   output logic [ERR_CNT_W-1:0]  err_cnt
`endif
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;

   localparam logic [1:0] MODE_EVEN  = 2'b00;
   localparam logic [1:0] MODE_ODD   = 2'b01;
   localparam logic [1:0] MODE_MARK  = 2'b10;
   localparam logic [1:0] MODE_SPACE = 2'b11;

   localparam logic [CNT_W-1:0] IDX_START  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] IDX_LAST   = CNT_W'(DATA_WIDTH);
   localparam logic [CNT_W-1:0] IDX_PARITY = CNT_W'(DATA_WIDTH + 1);

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      idx_q, idx_d;
   logic                  acc_q, acc_d;
   logic                  en_q, en_d;
   logic [1:0]            mode_q, mode_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   // Expected parity bit for the frame's latched mode and accumulated data parity.
   function automatic logic expected_parity(input logic [1:0] mode, input logic acc);
      logic exp_bit;
      case (mode)
         MODE_EVEN:  exp_bit = acc;
         MODE_ODD:   exp_bit = ~acc;
         MODE_MARK:  exp_bit = 1'b1;
         MODE_SPACE: exp_bit = 1'b0;
         default:    exp_bit = 1'b0;
      endcase
      return exp_bit;
   endfunction

   // Next-state logic: frame start, data collection, parity check and abort.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      en_d    = en_q;
      mode_d  = mode_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = err_q;

      if (frame_abort) begin
         // Abort wins over a coincident sample; captured data is kept.
         state_d = ST_IDLE;
         acc_d   = 1'b0;
         err_d   = 1'b0;
      end else if (sample_valid) begin
         if (bit_cnt == IDX_START) begin
            // A start-bit sample always (re)starts a frame, whatever the state.
            state_d = ST_DATA;
            idx_d   = CNT_W'(1);
            acc_d   = 1'b0;
            en_d    = par_en;
            mode_d  = par_mode;
            data_d  = {DATA_WIDTH{1'b0}};
            err_d   = 1'b0;
         end else begin
            case (state_q)
               ST_DATA: begin
                  if (bit_cnt == idx_q) begin
                     for (int i = 0; i < DATA_WIDTH; i++) begin
                        if (idx_q == CNT_W'(i + 1)) begin
                           data_d[i] = sampled_bit;
                        end else begin
                           data_d[i] = data_q[i];
                        end
                     end
                     acc_d = acc_q ^ sampled_bit;
                     if (idx_q == IDX_LAST) begin
                        if (en_q) begin
                           state_d = ST_PARITY;
                        end else begin
                           state_d = ST_IDLE;
                           done_d  = 1'b1;
                           err_d   = 1'b0;
                        end
                     end else begin
                        idx_d = idx_q + CNT_W'(1);
                     end
                  end else begin
                     state_d = ST_DATA;
                  end
               end
               ST_PARITY: begin
                  if (bit_cnt == IDX_PARITY) begin
                     err_d   = (sampled_bit != expected_parity(mode_q, acc_q));
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_PARITY;
                  end
               end
               default: begin
                  // IDLE ignores non-start samples; an illegal code recovers to IDLE.
                  state_d = ST_IDLE;
               end
            endcase
         end
      end else begin
         state_d = state_q;
      end
   end

   // Frame state registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         idx_q   <= {CNT_W{1'b0}};
         acc_q   <= 1'b0;
         en_q    <= 1'b0;
         mode_q  <= 2'b00;
         data_q  <= {DATA_WIDTH{1'b0}};
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         en_q    <= en_d;
         mode_q  <= mode_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign par_data = data_q;
   assign par_done = done_q;
   assign par_err  = err_q;

`ifdef PAR_CHK_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   // Count completed frames with a parity error, saturating at all-ones.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (done_d && err_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // Error counter register; only reset clears it.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         err_cnt_q <= {ERR_CNT_W{1'b0}};
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule
